// File: rtl/uart_if.sv
// Receiver-to-consumer link: the serial line in, and the received word out via valid/ready.
// The word moves on any clock edge where valid && ready. The producer holds data stable while valid is high.
interface uart_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  sig;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    // master: the receiver. slave: the consumer of received words.
    modport master (input sig, input ready, output data, output valid);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, DATA_WIDTH data bits sent LSB first, 1 stop bit.
// Each received word is presented on rxif.data with a valid/ready handshake.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 100_000_000
) (
    input  logic    clk,
    input  logic    rstn,
    uart_if.master  rxif
);
    localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(PULSE_WIDTH / 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [IDX_W-1:0]      idx, idx_n;
    logic [DATA_WIDTH-1:0] shift;
    logic                  sig_meta, s_sig;
    logic                  sample, load;

    // The line is asynchronous. The synchronizer resets to 1, the idle level of the line.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sig_meta <= 1'b1;
            s_sig    <= 1'b1;
        end else begin
            sig_meta <= rxif.sig;
            s_sig    <= sig_meta;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
        end
    end

    // START waits half a bit period, to the middle of the start bit.
    // Each later state waits one full bit period, so every sample lands mid-bit.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sample  = 1'b0;
        load    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!s_sig) state_n = START;
            end
            START: begin
                if (cnt == CNT_MID) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = s_sig ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n  = '0;
                    sample = 1'b1;
                    if (idx == IDX_LAST) state_n = STOP;
                    else                 idx_n   = idx + IDX_ONE;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (s_sig) begin
                        load    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = BREAK;
                    end
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            BREAK: begin
                // Framing error: wait for the line to return high before looking for a new start bit.
                cnt_n = '0;
                if (s_sig) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // A new word overrides a handshake on the same edge, so an overrun keeps valid high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift      <= '0;
            rxif.data  <= '0;
            rxif.valid <= 1'b0;
        end else begin
            if (sample) shift[idx] <= s_sig;
            if (load) begin
                rxif.data  <= shift;
                rxif.valid <= 1'b1;
            end else if (rxif.valid && rxif.ready) begin
                rxif.valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx. The bench shortens the bit period to 10 clocks
// (10 MHz clock at 1 Mbit/s) so the full byte sweep stays short.
module tb_uart_rx;
    localparam int DW  = 8;
    localparam int BR  = 1_000_000;
    localparam int CF  = 10_000_000;
    localparam int PW  = CF / BR;

    logic clk;
    logic rstn;
    int   pass_cnt;
    int   total_cnt;

    uart_if #(.DATA_WIDTH(DW)) rxif ();

    uart_rx #(.DATA_WIDTH(DW), .BAUD_RATE(BR), .CLK_FREQ(CF)) dut (
        .clk  (clk),
        .rstn (rstn),
        .rxif (rxif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_clk(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic line_hold(input logic v, input int n);
        rxif.sig = v;
        wait_clk(n);
    endtask

    task automatic send_frame(input logic [DW-1:0] b, input logic stop_bit);
        line_hold(1'b0, PW);
        for (int i = 0; i < DW; i++) line_hold(b[i], PW);
        line_hold(stop_bit, PW);
        rxif.sig = 1'b1;
    endtask

    task automatic pulse_ready;
        rxif.ready = 1'b1;
        @(negedge clk);
        rxif.ready = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] b;
        pass_cnt   = 0;
        total_cnt  = 0;
        rstn       = 1'b0;
        rxif.sig   = 1'b1;
        rxif.ready = 1'b0;
        wait_clk(100);
        check("reset_valid", {31'd0, rxif.valid}, 32'd0);
        check("reset_data", {24'd0, rxif.data}, 32'd0);
        rstn = 1'b1;
        wait_clk(5);

        // Every byte value, with a randomly delayed one-cycle ready after each word.
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            send_frame(b, 1'b1);
            check("sweep_valid", {31'd0, rxif.valid}, 32'd1);
            check("sweep_data", {24'd0, rxif.data}, {24'd0, b});
            wait_clk($urandom_range(PW / 2, PW));
            check("sweep_hold", {31'd0, rxif.valid}, 32'd1);
            pulse_ready();
            check("sweep_clear", {31'd0, rxif.valid}, 32'd0);
        end

        // Backpressure: the word waits while ready is held low.
        send_frame(8'hA5, 1'b1);
        for (int i = 0; i < 10; i++) begin
            wait_clk(500);
            check("hold_valid", {31'd0, rxif.valid}, 32'd1);
            check("hold_data", {24'd0, rxif.data}, 32'hA5);
        end
        pulse_ready();
        check("hold_clear", {31'd0, rxif.valid}, 32'd0);
        pulse_ready();
        check("idle_ready_valid", {31'd0, rxif.valid}, 32'd0);
        check("idle_ready_data", {24'd0, rxif.data}, 32'hA5);

        // A low pulse shorter than half a bit is rejected as a glitch.
        line_hold(1'b0, 3);
        line_hold(1'b1, 2 * PW);
        check("glitch_valid", {31'd0, rxif.valid}, 32'd0);
        send_frame(8'h3C, 1'b1);
        check("post_glitch_valid", {31'd0, rxif.valid}, 32'd1);
        check("post_glitch_data", {24'd0, rxif.data}, 32'h3C);
        pulse_ready();

        // Framing error: the frame is dropped, and the previous data is unchanged.
        send_frame(8'h55, 1'b0);
        line_hold(1'b1, 2 * PW);
        check("frame_err_valid", {31'd0, rxif.valid}, 32'd0);
        check("frame_err_data", {24'd0, rxif.data}, 32'h3C);
        send_frame(8'h12, 1'b1);
        check("post_err_valid", {31'd0, rxif.valid}, 32'd1);
        check("post_err_data", {24'd0, rxif.data}, 32'h12);
        pulse_ready();
        wait_clk(PW);

        // Overrun: two frames back to back with no ready in between.
        send_frame(8'h11, 1'b1);
        check("overrun_first", {24'd0, rxif.data}, 32'h11);
        send_frame(8'h22, 1'b1);
        check("overrun_valid", {31'd0, rxif.valid}, 32'd1);
        check("overrun_data", {24'd0, rxif.data}, 32'h22);

        // Reset arrives during the data bits of 0x77, while 0x22 is still unconsumed.
        b = 8'h77;
        line_hold(1'b0, PW);
        for (int i = 0; i < 3; i++) line_hold(b[i], PW);
        rstn = 1'b0;
        #1;
        check("midreset_valid", {31'd0, rxif.valid}, 32'd0);
        check("midreset_data", {24'd0, rxif.data}, 32'd0);
        rxif.sig = 1'b1;
        wait_clk(5);
        rstn = 1'b1;
        wait_clk(2 * PW);
        check("post_reset_idle", {31'd0, rxif.valid}, 32'd0);
        send_frame(8'h81, 1'b1);
        check("post_reset_valid", {31'd0, rxif.valid}, 32'd1);
        check("post_reset_data", {24'd0, rxif.data}, 32'h81);
        pulse_ready();
        check("post_reset_clear", {31'd0, rxif.valid}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: deserializes an asynchronous 8N1-style serial line (1 start, DATA_WIDTH data bits LSB-first, 1 stop) into a parallel word.
- Presents the word through a valid/ready handshake.
- Sits between the external RX pin and on-chip consumers.
- Connects through the shared uart_if interface; the receiver drives data/valid and samples sig/ready.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame; also the width of uart_if.data.
- BAUD_RATE, 115200, serial bit rate in bit/s.
- CLK_FREQ, 100_000_000, clk frequency in Hz.
- Parameter order is positional: DATA_WIDTH, BAUD_RATE, CLK_FREQ.
- Derived: PULSE_WIDTH = CLK_FREQ / BAUD_RATE, integer division (868 clocks at defaults).

Ports:
- clk, input, 1, system clock; the only clock.
- rstn, input, 1, asynchronous active-low reset.
- rxif.sig, input, 1, serial line; idles high; asynchronous to clk.
- rxif.data, output, DATA_WIDTH, received word.
- rxif.valid, output, 1, rxif.data holds an unconsumed word.
- rxif.ready, input, 1, consumer accepts the word.
- rxif is a uart_if #(DATA_WIDTH) instance.

Behaviour:
- Reset:
  - rstn low asynchronously forces state IDLE, counters 0, shift register 0, rxif.data 0, rxif.valid 0.
  - Synchronizer flops reset to 1 (line idle).
  - Reset mid-frame aborts the frame; no valid is produced.
- Input synchronization: rxif.sig passes through a 2-flop synchronizer. All decisions use the synchronized value (s_sig).
- Bit-period counter: counts 0..PULSE_WIDTH-1 clocks. The mid-bit point is count PULSE_WIDTH/2.
- State machine:
  - IDLE: wait for s_sig == 0 (falling edge/low). Then go to START with the counter cleared.
  - START: at mid-bit, if s_sig == 0, clear the counter and go to DATA with bit index 0. If s_sig == 1, treat as a glitch and return to IDLE.
  - DATA: every PULSE_WIDTH clocks after the mid-start point, sample s_sig into shift[index], LSB first. After index DATA_WIDTH-1, go to STOP.
  - STOP: after a further PULSE_WIDTH clocks (mid stop bit), sample s_sig.
    - If 1: load rxif.data with the shift register, set rxif.valid on the next edge, go to IDLE.
    - If 0 (framing error): discard the word, leave valid and data unchanged, go to IDLE only once s_sig returns to 1.
- Latency: rxif.valid rises about 9.5 bit periods plus 3 clocks after the start-bit falling edge on rxif.sig. This is before the end of the stop bit, so a frame whose stop bit lasts PULSE_WIDTH clocks yields valid within it.
- Handshake:
  - rxif.valid stays high and rxif.data stays stable until a clock edge with valid && ready.
  - On that edge valid clears; data keeps its value.
  - ready while valid is low has no effect.
- Overrun: if a new frame completes while valid is still high, data is overwritten with the new word and valid stays high. No error flag.
- Simultaneous: when valid && ready coincides with a new word load on the same edge, the load wins and valid stays 1.
- Receive runs continuously and independently of the handshake. A new start bit may begin immediately after the stop bit.

Test Plan:
- Reset for 100 clk, then send bytes 0x00..0xFF, each with PULSE_WIDTH=868 clocks per bit. After the stop bit, wait for valid, compare data, and pulse ready for 1 clk after a random 434..868 clk delay -> all 256 bytes match and valid clears after each ready.
- Send 0xA5, hold ready low for 5000 clk -> valid stays 1 and data stays 0xA5 throughout. Pulse ready -> valid 0 next edge.
- Glitch: drive sig low for 100 clk then high -> no frame, valid stays 0, next valid frame 0x3C is received correctly.
- Framing error: send 0x55 with stop bit 0 for a full bit, then idle high -> valid stays 0. A following 0x12 is received correctly.
- Overrun: send 0x11 then 0x22 back-to-back without ready -> valid 1, data 0x22.
- Assert rstn low during the data bits of 0x77 -> valid 0 and data 0 immediately. After release, 0x81 is received correctly.
